// File: rtl/regfile_sb_if.sv
// Issue/writeback/read bundle between the pipeline and the scoreboarded register file.
// Latency: none of its own; it only carries wires.
// Backpressure: none; rdy0/rdy1 are advisory stall hints for issue logic.
interface regfile_sb_if #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(NUM_REGS + 1);

    logic                 we0;
    logic                 we1;
    logic [ADDR_W-1:0]    wa0;
    logic [ADDR_W-1:0]    wa1;
    logic [WORD_SIZE-1:0] wd0;
    logic [WORD_SIZE-1:0] wd1;
    logic [ADDR_W-1:0]    ra0;
    logic [ADDR_W-1:0]    ra1;
    logic [WORD_SIZE-1:0] rv0;
    logic [WORD_SIZE-1:0] rv1;
    logic                 rdy0;
    logic                 rdy1;
    logic                 iss_en;
    logic [ADDR_W-1:0]    iss_rd;
    logic [CNT_W-1:0]     busy_cnt;

    modport master (
        output we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, iss_en, iss_rd,
        input  rv0, rv1, rdy0, rdy1, busy_cnt
    );

    modport slave (
        input  we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, iss_en, iss_rd,
        output rv0, rv1, rdy0, rdy1, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file with pending-write scoreboard; REGFILE_BYPASS_EN adds write-to-read bypass.
// Latency: write-to-read 1 cycle (0 with bypass); issue-to-rdy 1 cycle; reads combinational.
// Backpressure: none; writes are always accepted, rdy only advises the issue stage.
module regfile_sb #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int CNT_W  = $clog2(NUM_REGS + 1);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [CNT_W-1:0]     busy_cnt_q;
    logic [CNT_W-1:0]     busy_cnt_d;

    logic                 wr_en  [2];
    logic [ADDR_W-1:0]    wr_adr [2];
    logic [WORD_SIZE-1:0] wr_dat [2];
    logic [ADDR_W-1:0]    rd_adr [2];
    logic [WORD_SIZE-1:0] rd_dat [2];
    logic                 rd_rdy [2];
    logic                 iss_vld;

    assign wr_en[0]  = bus.we0 && (bus.wa0 != '0);
    assign wr_en[1]  = bus.we1 && (bus.wa1 != '0);
    assign wr_adr[0] = bus.wa0;
    assign wr_adr[1] = bus.wa1;
    assign wr_dat[0] = bus.wd0;
    assign wr_dat[1] = bus.wd1;
    assign rd_adr[0] = bus.ra0;
    assign rd_adr[1] = bus.ra1;
    assign iss_vld   = bus.iss_en && (bus.iss_rd != '0);

    // Clears from writeback first, then issue sets: a new producer outranks the retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                busy_d[wr_adr[p]] = 1'b0;
            end
        end
        if (iss_vld) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Port 1 is applied last so it wins a same-address collision; register 0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p]) begin
                    regs_q[wr_adr[p]] <= wr_dat[p];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = regs_q[rd_adr[p]];
            rd_rdy[p] = ~busy_q[rd_adr[p]];
`ifdef REGFILE_BYPASS_EN
            begin
                logic hit;
                hit = 1'b0;
                for (int w = 0; w < 2; w++) begin
                    if (wr_en[w] && (wr_adr[w] == rd_adr[p])) begin
                        rd_dat[p] = wr_dat[w];
                        hit       = 1'b1;
                    end
                end
                if (hit && !(iss_vld && (bus.iss_rd == rd_adr[p]))) begin
                    rd_rdy[p] = 1'b1;
                end
            end
`endif
        end
    end

    assign bus.rv0      = rd_dat[0];
    assign bus.rv1      = rd_dat[1];
    assign bus.rdy0     = rd_rdy[0];
    assign bus.rdy1     = rd_rdy[1];
    assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the processor's integer register file, sitting between decode/issue and writeback. It adds a second write port, a per-register scoreboard of pending writes, and an optional write-to-read bypass. Issue logic stalls on the `rdy*` outputs; writeback drives both write ports.

## Interface
- `WORD_SIZE`, default 32: data width of each register.
- `NUM_REGS`, default 32: number of registers; must be a power of two, at least 2. `ADDR_W = $clog2(NUM_REGS)` is derived locally and is not overridable.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `we0` / `we1`  in  1  write enable, port 0 / port 1.
- `wa0` / `wa1`  in  `ADDR_W`  write address, port 0 / port 1.
- `wd0` / `wd1`  in  `WORD_SIZE`  write data, port 0 / port 1.
- `ra0` / `ra1`  in  `ADDR_W`  read address, port 0 / port 1.
- `rv0` / `rv1`  out  `WORD_SIZE`  read data, combinational.
- `rdy0` / `rdy1`  out  1  operand at `ra0` / `ra1` has no pending write; combinational.
- `iss_en`  in  1  issue strobe: marks `iss_rd` as having a pending write.
- `iss_rd`  in  `ADDR_W`  destination register of the issuing instruction.
- `busy_cnt`  out  `$clog2(NUM_REGS+1)`  number of registers currently marked busy; registered.

## Operation
- Storage is `NUM_REGS` x `WORD_SIZE` flops plus a `busy` bit vector of `NUM_REGS` bits.
- Register 0 is hardwired to zero:
  - Writes to address 0 are ignored.
  - Issue to address 0 is ignored.
  - `busy[0]` is always 0.
  - Reads of address 0 return 0, with or without bypass.
- Write: on the rising edge with `weN`=1 and `waN`≠0, `reg[waN] <= wdN`. If both ports target the same nonzero address in one cycle, port 1 wins.
- Writeback clears the scoreboard: each enabled write port with nonzero address clears `busy[waN]` on the same edge.
- Issue: on the rising edge with `iss_en`=1 and `iss_rd`≠0, `busy[iss_rd] <= 1`.
  - Issue and writeback to the same register in the same cycle leave the bit set, because issue wins (new pending producer).
  - Issue to an already-busy register keeps it busy; there is no error flag.
- `busy_cnt` is the popcount of `busy` and is updated on the same edge as the bits. It is never negative and never exceeds `NUM_REGS-1`.
- Read: `rvN = reg[raN]`, and `rdyN = ~busy[raN]`, both from registered state unless the bypass is enabled (see Configuration).

## Timing
- Reset values: all registers 0, `busy` all 0, `busy_cnt` = 0. Hence `rv0`/`rv1` = 0 and `rdy0`/`rdy1` = 1 while in reset and immediately after.
- Reset asserted mid-operation discards all pending writes and scoreboard state asynchronously. Writes presented in the cycle reset deasserts are not taken if reset is still low at the edge.
- Without bypass:
  - A write becomes visible on `rv` in the cycle after its edge (1-cycle latency).
  - `rdy` rises in the cycle after writeback.
- Issue: `rdy` for that register falls in the cycle after the `iss_en` edge. `busy_cnt` reflects the issue from that same cycle.
- Reads have zero latency and no handshake. `rdy` is advisory: the block never blocks a write.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When a read address matches an enabled write in the same cycle (nonzero address), `rvN` returns that write data combinationally. If both ports match, port 1 data is returned.
  - `rdyN` is forced to 1 for that read address unless `iss_en` targets the same register in the same cycle.
  - Write-to-read latency becomes 0 cycles.
- Not defined: reads and `rdy` come from registered state only, with 1-cycle latency. No combinational path exists from `wd*`/`we*` to `rv*`/`rdy*`.

## Test plan
- Reset sequence:
  - Stimulus: hold `rst`=0, drive random writes and issues, then release.
  - Expected: every register reads 0, `rdy0` = `rdy1` = 1, `busy_cnt` = 0.
- Write to register 0:
  - Stimulus: `we0`=1, `wa0`=0, `wd0`=32'hDEADBEEF, plus `iss_en` to `iss_rd`=0.
  - Expected: `ra0`=0 reads 0, `busy_cnt` stays 0.
- Dual-write collision:
  - Stimulus: `we0`/`we1` both to address 5 with data 32'h11 and 32'h22.
  - Expected: the next cycle reads 32'h22.
  - Also: with the macro defined, `rv0` at `ra0`=5 shows 32'h22 in the same cycle.
- Scoreboard lifecycle:
  - Stimulus: issue to 7, then issue to 9.
  - Expected: `busy_cnt` goes 1, then 2, and `rdy` at 7 = 0.
  - Stimulus: write port 0 to 7 with 32'hA5.
  - Expected: next cycle `rdy`=1, `rv`=32'hA5, `busy_cnt`=1.
- Issue/writeback race:
  - Stimulus: `iss_rd`=3 issued in the same cycle as `we1` to address 3.
  - Expected: `busy[3]` stays 1, the data is written, and `busy_cnt` is unchanged.
- Async reset with 4 registers busy:
  - Stimulus: assert `rst` between clock edges while 4 registers are busy.
  - Expected: `busy_cnt` = 0 immediately, and all `rdy` = 1 before the next edge.
